// File: rtl/cnn_accel_pkg.sv
// Shared types and constants for the CNN accelerator output path.
package cnn_accel_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Slack kept below a full buffer so in-flight upstream pushes still land.
  localparam int AF_MARGIN = 4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read and registered flags/count.
module sync_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            din,
  output logic [DW-1:0]            dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;
  logic [CW-1:0] count_next;

  // A push into a full FIFO is still taken when the head leaves in the same cycle.
  assign do_pop     = pop && !empty;
  assign do_push    = push && (!full || do_pop);
  assign count_next = count + CW'(do_push) - CW'(do_pop);
  assign dout       = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/out_fm_st_engine.sv
// Streams an output feature-map tile from a FIFO to memory in c/r/n order.
// Optional sticky overflow detection is enabled by defining OUT_FM_ST_OVF_CHECK_EN.
module out_fm_st_engine
  import cnn_accel_pkg::*;
#(
  parameter int MAW        = 32,
  parameter int DW         = 32,
  parameter int Tn         = 16,
  parameter int Tr         = 64,
  parameter int Tc         = 16,
  parameter int FIFO_DEPTH = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   out_fm_st_fifo_data,
  input  logic            out_fm_st_fifo_push,
  output logic            out_fm_st_fifo_almost_full,
  input  logic            st_start,
  input  logic [MAW-1:0]  base_addr,
  input  logic [MAW-1:0]  row_stride,
  input  logic [MAW-1:0]  ch_stride,
  output logic [MAW-1:0]  mem_wr_addr,
  output logic [DW-1:0]   mem_wr_data,
  output logic            mem_wr_valid,
  input  logic            mem_wr_ready,
  output logic            busy,
  output logic            st_done,
  output logic            ovf_err
);

  localparam int TILE_WORDS = Tn * Tr * Tc;
  localparam int CNTW       = $clog2(FIFO_DEPTH) + 1;
  localparam int CW         = (Tc > 1) ? $clog2(Tc) : 1;
  localparam int RW         = (Tr > 1) ? $clog2(Tr) : 1;
  localparam int NW         = (Tn > 1) ? $clog2(Tn) : 1;
  localparam int WW         = $clog2(TILE_WORDS + 1);
  localparam logic [CNTW-1:0] AF_LEVEL = CNTW'(FIFO_DEPTH - AF_MARGIN);

  state_t         state;
  logic           armed;
  logic [CW-1:0]  c_cnt;
  logic [RW-1:0]  r_cnt;
  logic [NW-1:0]  n_cnt;
  logic [WW-1:0]  remaining;
  logic [MAW-1:0] row_stride_q;
  logic [MAW-1:0] ch_stride_q;
  logic [MAW-1:0] ch_base;
  logic [MAW-1:0] row_base;
  logic [MAW-1:0] cur_addr;

  logic [DW-1:0]   fifo_dout;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CNTW-1:0] fifo_count;
  logic [CNTW-1:0] count_next;
  logic            accept;
  logic            push_ok;
  logic            last_c;
  logic            last_r;

  sync_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (out_fm_st_fifo_push),
    .pop   (accept),
    .din   (out_fm_st_fifo_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // armed delays the first request by one RUN cycle after the start pulse.
  assign mem_wr_valid = (state == RUN) && armed && !fifo_empty;
  assign mem_wr_data  = mem_wr_valid ? fifo_dout : '0;
  assign mem_wr_addr  = cur_addr;
  assign accept       = mem_wr_valid && mem_wr_ready;
  assign busy         = (state != IDLE);
  assign st_done      = (state == DONE);
  assign last_c       = (c_cnt == CW'(Tc - 1));
  assign last_r       = (r_cnt == RW'(Tr - 1));
  assign push_ok      = out_fm_st_fifo_push && (!fifo_full || accept);
  assign count_next   = fifo_count + CNTW'(push_ok) - CNTW'(accept);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_fm_st_fifo_almost_full <= 1'b0;
    end else begin
      out_fm_st_fifo_almost_full <= (count_next >= AF_LEVEL);
    end
  end

  // Addresses advance by addition only: row and channel bases carry the strides.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      armed        <= 1'b0;
      c_cnt        <= '0;
      r_cnt        <= '0;
      n_cnt        <= '0;
      remaining    <= '0;
      row_stride_q <= '0;
      ch_stride_q  <= '0;
      ch_base      <= '0;
      row_base     <= '0;
      cur_addr     <= '0;
    end else begin
      case (state)
        IDLE: begin
          armed <= 1'b0;
          if (st_start) begin
            row_stride_q <= row_stride;
            ch_stride_q  <= ch_stride;
            ch_base      <= base_addr;
            row_base     <= base_addr;
            cur_addr     <= base_addr;
            c_cnt        <= '0;
            r_cnt        <= '0;
            n_cnt        <= '0;
            remaining    <= WW'(TILE_WORDS);
            state        <= RUN;
          end
        end
        RUN: begin
          armed <= 1'b1;
          if (accept) begin
            remaining <= remaining - WW'(1);
            if (remaining == WW'(1)) state <= DONE;
            if (!last_c) begin
              c_cnt    <= c_cnt + CW'(1);
              cur_addr <= cur_addr + MAW'(1);
            end else if (!last_r) begin
              c_cnt    <= '0;
              r_cnt    <= r_cnt + RW'(1);
              row_base <= row_base + row_stride_q;
              cur_addr <= row_base + row_stride_q;
            end else begin
              c_cnt    <= '0;
              r_cnt    <= '0;
              n_cnt    <= n_cnt + NW'(1);
              ch_base  <= ch_base + ch_stride_q;
              row_base <= ch_base + ch_stride_q;
              cur_addr <= ch_base + ch_stride_q;
            end
          end
        end
        DONE: begin
          armed <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef OUT_FM_ST_OVF_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_err <= 1'b0;
    end else if (out_fm_st_fifo_push && fifo_full && !accept) begin
      ovf_err <= 1'b1;
    end
  end
`else
  assign ovf_err = 1'b0;
`endif

endmodule
